// File: rtl/mips_mem_responder_if.sv
// Memory-bus and loader bundle between the host/core side and the responder.
interface mips_mem_responder_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ADRBITS = 6
);
  logic               ld_start;
  logic               ld_valid;
  logic [WIDTH-1:0]   ld_data;
  logic               ld_last;
  logic               ld_ready;
  logic               cpu_reset;
  logic               memread;
  logic               memwrite;
  logic [ADRBITS-1:0] adr;
  logic [WIDTH-1:0]   writedata;
  logic [WIDTH-1:0]   memdata;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               err;

  // Host loader and core side.
  modport master (
    output ld_start, ld_valid, ld_data, ld_last,
    output memread, memwrite, adr, writedata,
    input  ld_ready, cpu_reset, memdata, out_valid, out_data, err
  );

  // Responder side.
  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last,
    input  memread, memwrite, adr, writedata,
    output ld_ready, cpu_reset, memdata, out_valid, out_data, err
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Byte-wide RAM serving the multicycle MIPS core, with a host program loader
// that holds the core in reset and an MMIO output port at the top address.
module mips_mem_responder #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ADRBITS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_mem_responder_if.slave  bus
);
  localparam int unsigned        DEPTH   = 1 << ADRBITS;
  localparam logic [ADRBITS-1:0] ADR_MAX = '1;

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ADRBITS-1:0] ptr_q, ptr_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               ld_ready_q, ld_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               mem_we;
  logic [ADRBITS-1:0] mem_wadr;
  logic [WIDTH-1:0]   mem_wdata;

  // Next-state, load pointer, RAM write port and output flop inputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    mem_wadr    = ptr_q;
    mem_wdata   = bus.ld_data;

    case (state_q)
      ST_LOAD: begin
        if (bus.ld_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + ADRBITS'(1);
          if (bus.ld_last || (ptr_q == ADR_MAX)) begin
            state_d = ST_RELEASE;
            ptr_d   = '0;
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.memwrite) begin
          mem_we    = 1'b1;
          mem_wadr  = bus.adr;
          mem_wdata = bus.writedata;
          if (bus.adr == ADR_MAX) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.writedata;
          end
        end
        if (bus.memread && bus.memwrite) begin
          err_d = 1'b1;
        end
        // A new load wins over a same-cycle collision: err clears on LOAD entry.
        if (bus.ld_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_LOAD;
        ptr_d   = '0;
      end
    endcase

    // Core stays in reset through LOAD and the one RELEASE cycle.
    cpu_reset_d = (state_d != ST_RUN);
    ld_ready_d  = (state_d == ST_LOAD);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      ptr_q       <= '0;
      cpu_reset_q <= 1'b1;
      ld_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cpu_reset_q <= cpu_reset_d;
      ld_ready_q  <= ld_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  // RAM array; contents deliberately survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wadr] <= mem_wdata;
    end
  end

  // Zero-latency read so the core captures memdata on the same edge.
  always_comb begin
    bus.memdata = '0;
    if ((state_q == ST_RUN) && bus.memread) begin
      bus.memdata = mem_q[bus.adr];
    end
  end

  assign bus.cpu_reset = cpu_reset_q;
  assign bus.ld_ready  = ld_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.err       = err_q;
endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Byte-wide memory responder on the far side of the multicycle MIPS core's memory bus: it returns `memdata` for core reads, commits core writes, and owns the program image. A loader front end fills the RAM from a host byte stream while holding the core in reset. It then releases the core and serves its bus. The highest address is a memory-mapped output port that strobes each stored byte to the host.

## Interface
- `WIDTH`, 8: data width; must match the core's `WIDTH`.
- `ADRBITS`, 6: address width; RAM depth is 2^ADRBITS bytes.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ld_start`  in  1  pulse: begin a new program load (RUN state only).
- `ld_valid`  in  1  host byte valid.
- `ld_data`  in  WIDTH  host byte.
- `ld_last`  in  1  marks the final byte of the image.
- `ld_ready`  out  1  responder accepts a host byte.
- `cpu_reset`  out  1  active-high synchronous reset to the core.
- `memread`  in  1  core read strobe.
- `memwrite`  in  1  core write strobe.
- `adr`  in  ADRBITS  core byte address.
- `writedata`  in  WIDTH  core store data.
- `memdata`  out  WIDTH  read data to the core.
- `out_valid`  out  1  one-cycle strobe: a store hit the MMIO address.
- `out_data`  out  WIDTH  last byte stored to the MMIO address.
- `err`  out  1  sticky: `memread` and `memwrite` were both high in the same cycle.

## Operation
- Reset values: state LOAD, load pointer 0, `cpu_reset`=1, `ld_ready`=1, `out_valid`=0, `out_data`=0, `err`=0. RAM contents are not cleared.

State machine: LOAD -> RELEASE -> RUN, and RUN -> LOAD on `ld_start`.

- **LOAD**
  - `ld_ready`=1 and `cpu_reset`=1.
  - On `ld_valid`, `mem[ptr]` is written with `ld_data`, then `ptr` increments.
  - If `ld_last` is set, or `ptr` equals 2^ADRBITS-1, the state goes to RELEASE and `ptr` is cleared.
  - Bytes beyond the image keep their old contents.
- **RELEASE**
  - Lasts one cycle.
  - `ld_ready`=0 and `cpu_reset`=1, so the core's PC register sees reset at least once after the last byte.
  - Next state is RUN.
- **RUN**
  - `cpu_reset`=0 and `ld_ready`=0; `ld_valid` is ignored.
  - `memdata` = `mem[adr]` combinationally when `memread`=1, and 0 otherwise.
  - `memwrite`=1 writes `mem[adr]` with `writedata` on the clock edge.
  - If `adr` = 2^ADRBITS-1, the write additionally:
    - loads `out_data` with `writedata`;
    - pulses `out_valid` for the following cycle.
  - `ld_start`=1 moves the state to LOAD, clears `ptr` and re-asserts `cpu_reset` from the next cycle. Any core write in that same cycle still commits.
- `memdata` is 0 outside RUN.
- `err` sets in RUN whenever `memread` and `memwrite` are both 1.
  - The write still commits; `memdata` still returns the pre-write byte.
  - `err` clears only on `rst_n` or on entry to LOAD.
- Addresses wrap: there is no out-of-range access because `adr` is exactly ADRBITS wide.

## Timing
- Read latency is 0 cycles. `memdata` is valid in the same cycle as `memread`, so the core's FETCHn and LBRD states capture it on that cycle's edge.
- Write latency is 1 edge. A read of the same address in the next cycle returns the new byte.
- Load handshake: a byte transfers on each edge where `ld_valid` and `ld_ready` are both 1. Throughput is 1 byte per cycle with no back-pressure in LOAD.
- A load of N bytes gives `cpu_reset` low exactly N+1 edges after the first accepted byte: N LOAD edges plus 1 RELEASE edge.
- `out_valid` is high for exactly one cycle after each MMIO store. Back-to-back MMIO stores give consecutive pulses.
- Asserting `rst_n` low mid-load or mid-run immediately forces the reset values. A partially loaded image stays in RAM but must be reloaded.

## Test plan
1. **Basic load.** Reset, then send 0x11,0x22,0x33,0x44 with `ld_last` on 0x44.
   - `cpu_reset` falls 5 edges after the first byte.
   - A core read of `adr`=2 returns 0x33 combinationally.
2. **Full-depth load.** Stream 64 bytes with no `ld_last`.
   - The state leaves LOAD after byte 64.
   - `mem[63]` holds the last byte and `ptr` returns to 0.
3. **Write then read.** In RUN, write 0xA5 to `adr`=0x10, then read `adr`=0x10 in the next cycle.
   - The read returns 0xA5.
   - `memdata`=0 in any cycle with `memread`=0.
4. **MMIO store.** Store 0x7E to `adr`=0x3F, then 0x7F in the next cycle.
   - `out_valid` pulses on two consecutive cycles.
   - `out_data` is 0x7E, then 0x7F.
   - `mem[0x3F]`=0x7F.
5. **Read/write collision.** In RUN, assert `memread` and `memwrite` together.
   - `err`=1 and stays set.
   - `ld_start` followed by a new load clears `err`.
6. **Reset and reload.** Drop `rst_n` mid-load after 3 bytes.
   - Outputs return to reset values immediately.
   - A subsequent 2-byte load places its bytes at addresses 0 and 1.
   - `ld_start` in RUN re-asserts `cpu_reset` on the next cycle.
